// File: rtl/aes_pipe_ctrl_if.sv
// aes_pipe_ctrl_if: stream, core and status signals of the AES pipeline controller
interface aes_pipe_ctrl_if #(parameter int DATA_W = 128);
    logic [DATA_W-1:0] in_V_dout;
    logic              in_V_empty_n;
    logic              in_V_read;
    logic [DATA_W-1:0] out_V_din;
    logic              out_V_full_n;
    logic              out_V_write;
    logic              key_write;
    logic [DATA_W-1:0] key_data;
    logic              text_write;
    logic [DATA_W-1:0] text_data;
    logic [DATA_W-1:0] enc_data;
    logic              enc_valid;
    logic              busy;
    logic              err;
    modport master (
        input  in_V_dout, in_V_empty_n, out_V_full_n, enc_data, enc_valid,
        output in_V_read, out_V_din, out_V_write, key_write, key_data,
               text_write, text_data, busy, err
    );
    modport slave (
        output in_V_dout, in_V_empty_n, out_V_full_n, enc_data, enc_valid,
        input  in_V_read, out_V_din, out_V_write, key_write, key_data,
               text_write, text_data, busy, err
    );
endinterface

// File: rtl/aes_pipe_ctrl.sv
// aes_pipe_ctrl: frames a header/key/text stream onto an AES core and buffers its results
module aes_pipe_ctrl #(
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 16,
    parameter int KEY_GAP    = 2
) (
    input logic             ap_clk,
    input logic             ap_rst,
    aes_pipe_ctrl_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(KEY_GAP + 1) + 1;

    typedef enum logic [1:0] {HDR, DRAIN, KEY, TEXT} state_t;

    state_t            state, state_nx;
    logic [31:0]       rem_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [CW-1:0]     in_flight, fifo_cnt;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              en, rd, credit_ok, pop, bad, push;
    logic              hdr_rd, key_rd, text_rd;

    function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 8; i++) r[8*i +: 8] = w[DATA_W-8-8*i +: 8];
        return r;
    endfunction

    // credit counts results the core may still return, so its output can never overflow the FIFO
    assign credit_ok = ({1'b0, in_flight} + {1'b0, fifo_cnt}) < (CW + 1)'(FIFO_DEPTH);
    assign en = (state == HDR || state == KEY) ? 1'b1 :
                (state == TEXT) ? (gap_cnt == '0 && credit_ok) : 1'b0;
    assign rd      = bus.in_V_empty_n && en && !ap_rst;
    assign hdr_rd  = rd && state == HDR;
    assign key_rd  = rd && state == KEY;
    assign text_rd = rd && state == TEXT;
    assign pop     = fifo_cnt != '0 && bus.out_V_full_n && !ap_rst;
    assign bad     = bus.enc_valid && (in_flight == '0 || (fifo_cnt == CW'(FIFO_DEPTH) && !pop));
    assign push    = bus.enc_valid && !bad;

    assign bus.in_V_read   = rd;
    assign bus.out_V_write = pop;
    assign bus.out_V_din   = mem[rd_ptr];
    assign bus.busy        = state != HDR || in_flight != '0 || fifo_cnt != '0;

    // next state; DRAIN holds off the new key until every block of the old key has returned
    always_comb begin
        state_nx = state;
        case (state)
            HDR:     if (rd) state_nx = DRAIN;
            DRAIN:   if (in_flight == '0) state_nx = KEY;
            KEY:     if (rd) state_nx = (rem_cnt == 32'd0) ? HDR : TEXT;
            TEXT:    if (rd && rem_cnt == 32'd1) state_nx = HDR;
            default: state_nx = HDR;
        endcase
    end

    // state, counters, error flag and the registered core-side writes
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state          <= HDR;
            rem_cnt        <= '0;
            gap_cnt        <= '0;
            in_flight      <= '0;
            fifo_cnt       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            bus.err        <= 1'b0;
            bus.key_write  <= 1'b0;
            bus.text_write <= 1'b0;
            bus.key_data   <= '0;
            bus.text_data  <= '0;
        end else begin
            state <= state_nx;
            if (hdr_rd) rem_cnt <= bus.in_V_dout[31:0];
            else if (text_rd) rem_cnt <= rem_cnt - 32'd1;
            if (key_rd) gap_cnt <= GW'(KEY_GAP);
            else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
            in_flight <= in_flight + CW'(text_rd) - CW'(push);
            fifo_cnt  <= fifo_cnt + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (bad) bus.err <= 1'b1;
            bus.key_write  <= key_rd;
            bus.text_write <= text_rd;
            if (key_rd) bus.key_data <= byte_rev(bus.in_V_dout);
            if (text_rd) bus.text_data <= byte_rev(bus.in_V_dout);
        end
    end

    // result storage; only entries between the pointers are ever visible, so no reset
    always_ff @(posedge ap_clk) begin
        if (push) mem[wr_ptr] <= byte_rev(bus.enc_data);
    end
endmodule

// File: tb/tb_aes_pipe_ctrl.sv
// tb_aes_pipe_ctrl: stream source, core model and result scoreboard for aes_pipe_ctrl
module tb_aes_pipe_ctrl;
    localparam int W = 128, D = 16, G = 2;

    logic ap_clk = 1'b0, ap_rst = 1'b1;
    aes_pipe_ctrl_if #(.DATA_W(W)) bus();
    aes_pipe_ctrl #(.DATA_W(W), .FIFO_DEPTH(D), .KEY_GAP(G)) dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus));
    always #5 ap_clk = ~ap_clk;

    typedef struct {logic [W-1:0] d; int due;} pend_t;
    typedef struct {int n; int lat; int full_pct; int stall_pct; int exp_w; int span;} vec_t;

    int checks = 0, fails = 0;
    logic [W-1:0] in_q[$], exp_q[$];
    int kind_q[$], kw_hist[$], enc_hist[$];
    pend_t pipe[$];
    int cyc = 0, lat = 30, stall_pct = 0, full_pct = 100;
    bit spur = 0, flush = 0, rd_p = 0, rst_p = 1;
    int rd_kind = -1;
    logic [W-1:0] rd_word = '0, kd = '0, td = '0;
    int text_reads = 0, outstanding = 0, max_out = 0, first_pop_reads = -1;
    int pops = 0, n_text_w = 0, tw_first = -1, tw_last = -1;

    function automatic logic [W-1:0] rev(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W / 8; i++) r[8*i +: 8] = w[W-8-8*i +: 8];
        return r;
    endfunction

    function automatic void chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    // one frame: header with N in the low 32 bits, key, N plaintexts; each result is plaintext ^ key
    task automatic send(input int n, input logic [W-1:0] k, input bit fixed, input logic [W-1:0] p0);
        logic [W-1:0] h, p;
        h = {4{$urandom}};
        h[31:0] = n;
        in_q.push_back(h);
        kind_q.push_back(0);
        in_q.push_back(k);
        kind_q.push_back(1);
        for (int i = 0; i < n; i++) begin
            p = (fixed && i == 0) ? p0 : {4{$urandom}};
            in_q.push_back(p);
            kind_q.push_back(2);
            exp_q.push_back(p ^ k);
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0 || pipe.size() != 0) && t < 5000) begin
            @(negedge ap_clk);
            t++;
        end
        chkb({name, "_timeout"}, t < 5000, 1'b1);
        repeat (3) @(negedge ap_clk);
        #1;
        chkb({name, "_busy"}, bus.busy, 1'b0);
        chkb({name, "_err"}, bus.err, 1'b0);
    endtask

    // stream source, core model and per-cycle checks of the registered core-side outputs
    initial begin
        pend_t e;
        bit kw_e, tw_e;
        bus.in_V_empty_n = 1'b0;
        bus.in_V_dout    = '0;
        bus.out_V_full_n = 1'b1;
        bus.enc_valid    = 1'b0;
        bus.enc_data     = '0;
        forever begin
            @(negedge ap_clk);
            cyc++;
            if (flush) begin
                in_q.delete();
                kind_q.delete();
                exp_q.delete();
                pipe.delete();
                flush = 0;
            end else if (rd_p) begin
                void'(in_q.pop_front());
                void'(kind_q.pop_front());
            end
            kw_e = rd_p && rd_kind == 1;
            tw_e = rd_p && rd_kind == 2;
            if (rst_p) begin
                kd = '0;
                td = '0;
            end
            if (kw_e) kd = rev(rd_word);
            if (tw_e) td = rev(rd_word);
            chkb("key_write", bus.key_write, kw_e);
            chkb("text_write", bus.text_write, tw_e);
            chkw("key_data", bus.key_data, kd);
            chkw("text_data", bus.text_data, td);
            if (bus.key_write) begin
                kw_hist.push_back(cyc);
                tw_first = -1;
            end
            if (bus.text_write) begin
                n_text_w++;
                if (tw_first < 0) tw_first = cyc;
                tw_last = cyc;
                e.d = bus.text_data ^ bus.key_data;
                e.due = cyc + lat;
                pipe.push_back(e);
            end
            bus.enc_valid = 1'b0;
            if (pipe.size() != 0 && pipe[0].due <= cyc) begin
                e = pipe.pop_front();
                bus.enc_valid = 1'b1;
                bus.enc_data = e.d;
                enc_hist.push_back(cyc);
            end else if (spur) begin
                bus.enc_valid = 1'b1;
                bus.enc_data = {4{$urandom}};
                spur = 0;
            end
            bus.in_V_empty_n = in_q.size() != 0 && int'($urandom_range(99)) >= stall_pct;
            bus.in_V_dout    = in_q.size() != 0 ? in_q[0] : {4{$urandom}};
            bus.out_V_full_n = int'($urandom_range(99)) < full_pct;
            #3;
            rst_p   = ap_rst;
            rd_p    = bus.in_V_read;
            rd_kind = kind_q.size() != 0 ? kind_q[0] : -1;
            rd_word = bus.in_V_dout;
            if (rst_p) outstanding = 0;
            if (rd_p && rd_kind == 2) begin
                text_reads++;
                outstanding++;
                if (outstanding > max_out) max_out = outstanding;
            end
            if (bus.out_V_write) begin
                pops++;
                outstanding--;
                if (first_pop_reads < 0) first_pop_reads = text_reads;
                if (exp_q.size() != 0) chkw("result", bus.out_V_din, exp_q.pop_front());
                else chkb("unexpected_result", bus.out_V_write, 1'b0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int t, base, nexp;
        tbl[0] = '{1, 5, 100, 0, 1, 0};
        tbl[1] = '{8, 3, 100, 0, 8, 7};
        tbl[2] = '{12, 20, 100, 0, 12, 11};
        tbl[3] = '{5, 30, 50, 30, 5, -1};
        tbl[4] = '{0, 10, 100, 0, 0, -1};
        tbl[5] = '{3, 1, 60, 50, 3, -1};

        send(2, 128'h000102030405060708090a0b0c0d0e0f, 1, 128'h00112233445566778899aabbccddeeff);
        repeat (3) @(negedge ap_clk);
        #1;
        chkb("rst_in_read", bus.in_V_read, 1'b0);
        chkb("rst_out_write", bus.out_V_write, 1'b0);
        chkb("rst_key_write", bus.key_write, 1'b0);
        chkb("rst_busy", bus.busy, 1'b0);
        chkb("rst_err", bus.err, 1'b0);
        chkw("rst_key_data", bus.key_data, '0);
        kw_hist.delete();
        n_text_w = 0;
        pops = 0;
        ap_rst = 1'b0;
        wait_idle("basic");
        chki("basic_key_writes", kw_hist.size(), 1);
        chki("basic_gap", tw_first - (kw_hist.size() != 0 ? kw_hist[0] : 0), G + 1);
        chki("basic_text_writes", n_text_w, 2);
        chki("basic_results", pops, 2);

        for (int i = 0; i < 6; i++) begin
            lat = tbl[i].lat;
            full_pct = tbl[i].full_pct;
            stall_pct = tbl[i].stall_pct;
            n_text_w = 0;
            pops = 0;
            send(tbl[i].n, {4{$urandom}}, 0, '0);
            wait_idle($sformatf("vec%0d", i));
            chki($sformatf("vec%0d_text_writes", i), n_text_w, tbl[i].exp_w);
            chki($sformatf("vec%0d_results", i), pops, tbl[i].exp_w);
            if (tbl[i].span >= 0) chki($sformatf("vec%0d_span", i), tw_last - tw_first, tbl[i].span);
        end

        lat = 30;
        full_pct = 0;
        stall_pct = 0;
        text_reads = 0;
        max_out = 0;
        first_pop_reads = -1;
        send(40, {4{$urandom}}, 0, '0);
        repeat (150) @(negedge ap_clk);
        #1;
        chki("bp_max_outstanding", max_out, D);
        chki("bp_text_reads", text_reads, D);
        chkb("bp_err", bus.err, 1'b0);
        full_pct = 100;
        wait_idle("bp");
        chki("bp_reads_before_pop", first_pop_reads, D);

        kw_hist.delete();
        enc_hist.delete();
        send(3, {4{$urandom}}, 0, '0);
        send(1, {4{$urandom}}, 0, '0);
        wait_idle("rekey");
        chki("rekey_keys", kw_hist.size(), 2);
        chki("rekey_encs", enc_hist.size(), 4);
        if (kw_hist.size() == 2 && enc_hist.size() == 4)
            chkb("rekey_drain", kw_hist[1] > enc_hist[2] + 1, 1'b1);

        kw_hist.delete();
        n_text_w = 0;
        send(0, {4{$urandom}}, 0, '0);
        send(2, {4{$urandom}}, 0, '0);
        wait_idle("n0");
        chki("n0_keys", kw_hist.size(), 2);
        chki("n0_text_writes", n_text_w, 2);

        for (int b = 0; b < 4; b++) begin
            lat = int'($urandom_range(40, 1));
            full_pct = int'($urandom_range(100, 30));
            stall_pct = int'($urandom_range(40));
            pops = 0;
            nexp = 0;
            for (int f = 0; f < 6; f++) begin
                t = int'($urandom_range(24));
                nexp += t;
                send(t, {4{$urandom}}, 0, '0);
            end
            wait_idle($sformatf("rand%0d", b));
            chki($sformatf("rand%0d_results", b), pops, nexp);
        end
        lat = 30;
        full_pct = 100;
        stall_pct = 0;

        spur = 1;
        t = 0;
        while (spur && t < 100) begin
            @(negedge ap_clk);
            t++;
        end
        chkb("spur_issued", spur, 1'b0);
        repeat (2) @(negedge ap_clk);
        #1;
        chkb("spur_err", bus.err, 1'b1);
        repeat (5) @(negedge ap_clk);
        #1;
        chkb("spur_err_sticky", bus.err, 1'b1);
        chkb("spur_fifo_empty", bus.out_V_write, 1'b0);
        #1;
        ap_rst = 1'b1;
        @(negedge ap_clk);
        #1;
        chkb("spur_rst_err", bus.err, 1'b0);
        chkb("spur_rst_busy", bus.busy, 1'b0);
        #1;
        ap_rst = 1'b0;

        send(10, {4{$urandom}}, 0, '0);
        base = text_reads;
        t = 0;
        while (text_reads < base + 4 && t < 500) begin
            @(negedge ap_clk);
            t++;
        end
        chkb("midrst_reached", text_reads >= base + 4, 1'b1);
        #2;
        ap_rst = 1'b1;
        flush = 1;
        #1;
        chkb("midrst_in_read", bus.in_V_read, 1'b0);
        @(negedge ap_clk);
        #1;
        chkb("midrst_key_write", bus.key_write, 1'b0);
        chkb("midrst_text_write", bus.text_write, 1'b0);
        chkw("midrst_key_data", bus.key_data, '0);
        chkw("midrst_text_data", bus.text_data, '0);
        chkb("midrst_out_write", bus.out_V_write, 1'b0);
        chkb("midrst_busy", bus.busy, 1'b0);
        chkb("midrst_err", bus.err, 1'b0);
        #1;
        ap_rst = 1'b0;
        pops = 0;
        send(2, {4{$urandom}}, 0, '0);
        wait_idle("midrst_fresh");
        chki("midrst_fresh_results", pops, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/aes_pipe_ctrl.md
AES_PIPE_CTRL -- requirements
Module: aes_pipe_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 128, cipher block and key width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, number of result entries in the internal output FIFO (power of 2, at least 4).
REQ-003 SHALL have parameter KEY_GAP, default 2, number of idle cycles between key_write and the first text_write.
REQ-004 SHALL have one clock and a synchronous active-high reset: ap_clk and ap_rst. All state changes on the rising edge of ap_clk.
REQ-005 SHALL have the following ports:
- ap_clk  in  1  system clock
- ap_rst  in  1  synchronous active-high reset
- in_V_dout  in  128  input stream word
- in_V_empty_n  in  1  input stream has a word
- in_V_read  out  1  pop the input stream
- out_V_din  out  128  result word
- out_V_full_n  in  1  output stream can accept a word
- out_V_write  out  1  push to the output stream
- key_write  out  1  key valid to the core
- key_data  out  128  key to the core
- text_write  out  1  plaintext valid to the core
- text_data  out  128  plaintext to the core
- enc_data  in  128  ciphertext from the core
- enc_valid  in  1  ciphertext valid from the core
- busy  out  1  state is not HDR, or in_flight is not 0, or the FIFO is not empty
- err  out  1  sticky protocol/overflow error

Function
REQ-006 The input stream format SHALL be: a header word (bits [31:0] = N, the number of blocks; upper bits ignored), then one key word, then N plaintext words, repeating.
REQ-007 The state machine SHALL have four states: HDR, DRAIN, KEY and TEXT.
- HDR: consume the header when in_V_empty_n=1, latch N into rem_cnt (32 bits), then go to DRAIN.
- DRAIN: wait until in_flight=0, then go to KEY.
- KEY: consume the key when in_V_empty_n=1; go to TEXT, or to HDR if N=0.
- TEXT: consume plaintext; decrement rem_cnt on each read; after the read that takes rem_cnt to 0, go to HDR.
REQ-008 in_V_read SHALL be combinational: in_V_empty_n AND a state-specific enable.
- HDR: enable is 1.
- KEY: enable is 1.
- TEXT: enable is (gap_cnt=0) AND credit_ok.
- DRAIN: enable is 0.
REQ-009 key_write and text_write SHALL be registered: asserted exactly one cycle after the corresponding in_V_read, with key_data/text_data equal to the byte-reversed consumed word (byte 0 [7:0] goes to [127:120]), and held until the next write.
REQ-010 gap_cnt SHALL load KEY_GAP on the key read and decrement to 0; no text read occurs while gap_cnt is not 0.
REQ-011 in_flight (width log2(FIFO_DEPTH)+1) SHALL behave as follows:
- +1 on a text read.
- -1 on enc_valid.
- Unchanged when both happen in the same cycle.
REQ-012 credit_ok SHALL equal (in_flight + fifo_cnt) < FIFO_DEPTH, so the non-stallable core output can never overflow the FIFO.
REQ-013 The FIFO SHALL push byte-reversed enc_data on enc_valid and pop when out_V_write. A simultaneous push and pop leaves fifo_cnt unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
REQ-014 out_V_write SHALL equal (fifo_cnt not 0) AND out_V_full_n, with out_V_din = FIFO head (first-word fall-through). A push into an empty FIFO is visible the next cycle.
REQ-015 err SHALL set on either of the following, and the offending enc_valid SHALL be dropped with counters unchanged:
- enc_valid with in_flight=0.
- enc_valid with fifo_cnt=FIFO_DEPTH and no simultaneous pop.
REQ-016 Results SHALL leave in plaintext order. Back-to-back text reads every cycle SHALL be sustained while credit_ok=1.

Reset
REQ-017 On ap_rst=1 the block SHALL clear the following on the same edge:
- State goes to HDR.
- rem_cnt, gap_cnt, in_flight, fifo_cnt, FIFO pointers and err are cleared.
- key_write and text_write are cleared.
- key_data and text_data are cleared to 0.
REQ-018 Reset mid-operation SHALL discard FIFO contents and in-flight accounting. enc_valid arriving after reset for pre-reset blocks SHALL set err (core flush is the integrator's responsibility).
REQ-019 in_V_read and out_V_write SHALL be 0 while ap_rst=1.

Verification
REQ-020 Basic flow: header N=2, key 000102..0F, plaintext 00112233..FF; core model latency 30 -> key_write 1 cycle after the key read; first text_write KEY_GAP+1 cycles later; 2 results out in order; busy returns to 0.
REQ-021 Backpressure: out_V_full_n=0, N=40, model latency 30 -> at most 16 text reads before the first result is popped; no err; in_V_read stalls at in_flight+fifo_cnt=16.
REQ-022 Rekey drain: two headers back to back (N=3, then N=1) -> second key_write occurs only after the third enc_valid.
REQ-023 N=0 header -> key consumed, no text_write, state back to HDR, next header accepted.
REQ-024 Error: spurious enc_valid at idle -> err=1 and stays 1, FIFO empty. ap_rst for 1 cycle -> err=0, busy=0.
REQ-025 Reset mid-burst (N=10 after 4 reads) -> all outputs at reset values next cycle; fresh header accepted.
